// File: rtl/mpmc10_strip_cmd_gen.sv
// mpmc10_strip_cmd_gen: issues one MIG command per strip of a multi-strip request, credit-gating writes and counting read returns.
module mpmc10_strip_cmd_gen #(
  parameter int ADDR_W   = 32,
  parameter int ADDR_INC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [5:0]        req_num_strips,
  output logic              busy,
  output logic              done,
  output logic [5:0]        strip_cnt,
  output logic [5:0]        num_strips,
  output logic [5:0]        rd_strip_cnt,
  input  logic              wdf_strip_done,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rd_data_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;
  state_t state, state_nx;
  logic [6:0] credit, credit_nx;
  logic acc, last, rd, rd_act, rd_last, inc, dec;
  always_comb begin
    acc       = app_en & app_rdy;
    last      = strip_cnt == num_strips;
    rd        = app_cmd[0];
    rd_act    = (state == ISSUE | state == WAIT_RD) & rd & app_rd_data_valid;
    rd_last   = rd_act & (rd_strip_cnt == num_strips);
    inc       = state == ISSUE & !rd & wdf_strip_done;
    dec       = state == ISSUE & !rd & acc;
    credit_nx = (inc & !dec & credit != 7'd64) ? credit + 7'd1 :
                (dec & !inc)                   ? credit - 7'd1 : credit;
    state_nx  = (state == IDLE)                 ? (req ? ISSUE : IDLE) :
                (state == DONE)                 ? IDLE :
                rd_last                         ? DONE :
                (state == ISSUE & acc & last)   ? (rd ? WAIT_RD : DONE) : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      app_en       <= 1'b0;
      app_cmd      <= 3'b000;
      app_addr     <= '0;
      strip_cnt    <= '0;
      num_strips   <= '0;
      rd_strip_cnt <= '0;
      credit       <= '0;
    end else if (state == IDLE) begin
      app_en <= 1'b0;
      if (req) begin
        app_cmd      <= {2'b00, !req_we};
        app_addr     <= req_adr;
        num_strips   <= req_num_strips;
        strip_cnt    <= '0;
        rd_strip_cnt <= '0;
        credit       <= '0;
      end
    end else begin
      credit <= credit_nx;
      // Stay asserted through backpressure; drop after the final acceptance or when write credits run out.
      app_en <= state == ISSUE & state_nx == ISSUE & (rd | credit_nx != 7'd0);
      if (state == ISSUE & acc & !last) begin
        strip_cnt <= strip_cnt + 6'd1;
        app_addr  <= app_addr + ADDR_W'(ADDR_INC);
      end
      if (rd_act & !rd_last) rd_strip_cnt <= rd_strip_cnt + 6'd1;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_mpmc10_strip_cmd_gen.sv
// tb_mpmc10_strip_cmd_gen: table-driven directed checks plus a hand-written mid-transaction reset sequence.
module tb_mpmc10_strip_cmd_gen;
  logic clk = 0, rst = 1, req = 0, req_we = 0, wdf_strip_done = 0, app_rdy = 0, app_rd_data_valid = 0;
  logic [31:0] req_adr = 0;
  logic [5:0] req_num_strips = 0;
  logic busy, done, app_en;
  logic [2:0] app_cmd;
  logic [31:0] app_addr;
  logic [5:0] strip_cnt, num_strips, rd_strip_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mpmc10_strip_cmd_gen #(.ADDR_W(32), .ADDR_INC(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_adr(req_adr),
    .req_num_strips(req_num_strips), .busy(busy), .done(done), .strip_cnt(strip_cnt),
    .num_strips(num_strips), .rd_strip_cnt(rd_strip_cnt), .wdf_strip_done(wdf_strip_done),
    .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rd_data_valid(app_rd_data_valid)
  );
  typedef struct {
    logic req, we; logic [31:0] adr; logic [5:0] ns; logic rdy, rdv, wdf;
    logic b, d, en; logic [2:0] cmd; logic [31:0] addr; logic [5:0] sc, rsc, nsx;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic req_i, we, input logic [31:0] adr, input logic [5:0] ns,
                     input logic rdy, rdv, wdf, b, d, en, input logic [2:0] cmd,
                     input logic [31:0] addr, input logic [5:0] sc, rsc, nsx);
    vec_t x;
    x = '{req_i, we, adr, ns, rdy, rdv, wdf, b, d, en, cmd, addr, sc, rsc, nsx};
    v.push_back(x);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string n, input logic b, d, en, input logic [2:0] cmd,
                         input logic [31:0] addr, input logic [5:0] sc, rsc, nsx);
    chk({n, ".busy"}, busy, b);
    chk({n, ".done"}, done, d);
    chk({n, ".app_en"}, app_en, en);
    chk({n, ".app_cmd"}, app_cmd, cmd);
    chk({n, ".app_addr"}, app_addr, addr);
    chk({n, ".strip_cnt"}, strip_cnt, sc);
    chk({n, ".rd_strip_cnt"}, rd_strip_cnt, rsc);
    chk({n, ".num_strips"}, num_strips, nsx);
  endtask
  initial begin
    // read burst, with an ignored second request at row 3
    add(1,0,'h1000,3,1,0,0, 1,0,0,1,'h1000,0,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1000,0,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1008,1,0,3);
    add(1,1,'h2000,7,1,0,0, 1,0,1,1,'h1010,2,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1018,3,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,0,1,'h1018,3,0,3);
    add(0,0,'h1000,3,1,1,0, 1,0,0,1,'h1018,3,1,3);
    add(0,0,'h1000,3,1,1,0, 1,0,0,1,'h1018,3,2,3);
    add(0,0,'h1000,3,1,1,0, 1,0,0,1,'h1018,3,3,3);
    add(0,0,'h1000,3,1,1,0, 1,1,0,1,'h1018,3,3,3);
    add(0,0,'h1000,3,1,0,0, 0,0,0,1,'h1018,3,3,3);
    // backpressure at strip 1
    add(1,0,'h1000,3,1,0,0, 1,0,0,1,'h1000,0,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1000,0,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1008,1,0,3);
    add(0,0,'h1000,3,0,0,0, 1,0,1,1,'h1008,1,0,3);
    add(0,0,'h1000,3,0,0,0, 1,0,1,1,'h1008,1,0,3);
    add(0,0,'h1000,3,0,0,0, 1,0,1,1,'h1008,1,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1010,2,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,1,1,'h1018,3,0,3);
    add(0,0,'h1000,3,1,0,0, 1,0,0,1,'h1018,3,0,3);
    add(0,0,'h1000,3,1,1,0, 1,0,0,1,'h1018,3,1,3);
    add(0,0,'h1000,3,1,0,0, 1,0,0,1,'h1018,3,1,3);
    add(0,0,'h1000,3,1,1,0, 1,0,0,1,'h1018,3,2,3);
    add(0,0,'h1000,3,1,1,0, 1,0,0,1,'h1018,3,3,3);
    add(0,0,'h1000,3,1,1,0, 1,1,0,1,'h1018,3,3,3);
    add(0,0,'h1000,3,1,0,0, 0,0,0,1,'h1018,3,3,3);
    // write credits, read data during a write is ignored
    add(1,1,'h3000,2,1,0,0, 1,0,0,0,'h3000,0,0,2);
    add(0,1,'h3000,2,1,0,0, 1,0,0,0,'h3000,0,0,2);
    add(0,1,'h3000,2,1,0,0, 1,0,0,0,'h3000,0,0,2);
    add(0,1,'h3000,2,1,0,1, 1,0,1,0,'h3000,0,0,2);
    add(0,1,'h3000,2,1,0,0, 1,0,0,0,'h3008,1,0,2);
    add(0,1,'h3000,2,1,1,0, 1,0,0,0,'h3008,1,0,2);
    add(0,1,'h3000,2,1,0,1, 1,0,1,0,'h3008,1,0,2);
    add(0,1,'h3000,2,1,0,1, 1,0,1,0,'h3010,2,0,2);
    add(0,1,'h3000,2,1,0,0, 1,1,0,0,'h3010,2,0,2);
    add(0,1,'h3000,2,1,0,0, 0,0,0,0,'h3010,2,0,2);
    // single strip, extra valid pulses after completion
    add(1,0,'h4000,0,1,0,0, 1,0,0,1,'h4000,0,0,0);
    add(0,0,'h4000,0,1,0,0, 1,0,1,1,'h4000,0,0,0);
    add(0,0,'h4000,0,1,0,0, 1,0,0,1,'h4000,0,0,0);
    add(0,0,'h4000,0,1,1,0, 1,1,0,1,'h4000,0,0,0);
    add(0,0,'h4000,0,1,1,0, 0,0,0,1,'h4000,0,0,0);
    add(0,0,'h4000,0,1,1,0, 0,0,0,1,'h4000,0,0,0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0,0,0,0,0,0,0,0);
    rst = 0;
    step();
    chk_all("post_reset", 0,0,0,0,0,0,0,0);
    foreach (v[i]) begin
      req = v[i].req; req_we = v[i].we; req_adr = v[i].adr; req_num_strips = v[i].ns;
      app_rdy = v[i].rdy; app_rd_data_valid = v[i].rdv; wdf_strip_done = v[i].wdf;
      step();
      chk_all($sformatf("row%0d", i), v[i].b, v[i].d, v[i].en, v[i].cmd, v[i].addr, v[i].sc, v[i].rsc, v[i].nsx);
    end
    // reset in the middle of ISSUE
    app_rd_data_valid = 0; wdf_strip_done = 0; app_rdy = 1;
    req = 1; req_we = 0; req_adr = 'h5000; req_num_strips = 5;
    step();
    req = 0;
    repeat (3) step();
    chk_all("mid_issue", 1,0,1,1,'h5010,2,0,5);
    rst = 1;
    #1;
    chk_all("async_rst", 0,0,0,0,0,0,0,0);
    step();
    chk_all("rst_held", 0,0,0,0,0,0,0,0);
    rst = 0;
    req = 1; req_adr = 'h6000; req_num_strips = 1;
    step();
    req = 0;
    chk_all("restart_req", 1,0,0,1,'h6000,0,0,1);
    step();
    chk_all("restart_en", 1,0,1,1,'h6000,0,0,1);
    step();
    chk_all("restart_adv", 1,0,1,1,'h6008,1,0,1);
    step();
    chk_all("restart_wait", 1,0,0,1,'h6008,1,0,1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mpmc10_strip_cmd_gen.md
# mpmc10_strip_cmd_gen

Strip command issuer for the mpmc10 controller. It accepts one multi-strip request from the port arbiter and issues one MIG command (`app_en`/`app_cmd`/`app_addr`) per strip. It holds each command until the MIG accepts it, gates writes on write-data credits, counts returned read strips, and reports completion. It produces the `strip_cnt`/`num_strips` view consumed by the app_en/state logic and sits directly between the arbiter and the MIG user interface.

## Interface
- `ADDR_W`, 32, width of request and MIG address
- `ADDR_INC`, 8, `app_addr` increment per strip (one BL8 burst)
- `clk`  in  1  controller clock; all logic is on its rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `req`  in  1  request strobe; sampled only in IDLE
- `req_we`  in  1  1 = write transaction, 0 = read transaction
- `req_adr`  in  ADDR_W  address of the first strip
- `req_num_strips`  in  6  index of the last strip (strip count minus 1)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `strip_cnt`  out  6  index of the strip currently being issued
- `num_strips`  out  6  latched copy of `req_num_strips`
- `rd_strip_cnt`  out  6  number of read strips returned so far
- `wdf_strip_done`  in  1  pulse: one strip of write data has been accepted by the MIG write FIFO
- `app_rdy`  in  1  MIG command ready
- `app_en`  out  1  MIG command valid (registered)
- `app_cmd`  out  3  MIG command: 3'b000 = write, 3'b001 = read
- `app_addr`  out  ADDR_W  MIG command address
- `app_rd_data_valid`  in  1  MIG read data valid; one pulse per strip

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- Acceptance is `acc = app_en & app_rdy`. `last = (strip_cnt == num_strips)`.
- **IDLE**, when `req` is high:
  - Latch `app_cmd` from `req_we`, `app_addr <= req_adr`, `num_strips <= req_num_strips`.
  - Clear `strip_cnt`, `rd_strip_cnt` and the credit counter.
  - Go to ISSUE. `app_en` stays 0 on this edge.
- **ISSUE**:
  - `app_en <= !(acc & last) & (read | credit_next != 0)`.
  - On `acc & !last`: `strip_cnt` += 1 and `app_addr` += `ADDR_INC`. Both wrap modulo their widths.
  - On `acc & last`: a write goes to DONE; a read goes to WAIT_RD.
  - `app_addr` and `app_cmd` are held stable while `app_en & !app_rdy`. The command is retried until accepted and never withdrawn.
- **Credit counter** (7 bits, writes only, non-IDLE states):
  - +1 on `wdf_strip_done`.
  - -1 on a write `acc`.
  - Both in the same cycle: the count is unchanged.
  - Saturates at 64.
  - `credit_next` is the post-update value.
- **Read return counting**, in ISSUE and WAIT_RD, reads only:
  - On `app_rd_data_valid & rd_strip_cnt != num_strips`: `rd_strip_cnt` += 1.
  - On `app_rd_data_valid & rd_strip_cnt == num_strips`: go to DONE. A transition taken from ISSUE on this condition is permitted.
- **DONE**: `done = 1` for one cycle, then IDLE. `busy` falls on entry to IDLE.
- **Ignored inputs**:
  - `req` outside IDLE.
  - `app_rd_data_valid` in IDLE and DONE, and during write transactions.
  - `wdf_strip_done` in IDLE and DONE, and during read transactions.
- **Reset**, at any time including mid-transaction:
  - Immediately returns to IDLE.
  - Outputs go to `app_en = 0`, `app_cmd = 0`, `app_addr = 0`, `strip_cnt = 0`, `num_strips = 0`, `rd_strip_cnt = 0`, `busy = 0`, `done = 0`.
  - Credits are cleared.
  - No `done` pulse is produced for the aborted transaction.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- A `req` sampled at edge N gives `busy = 1` after N and the first `app_en = 1` after N+1 (reads or pre-credited writes).
- A write with zero credits: a `wdf_strip_done` sampled at edge M gives `app_en = 1` after M.
- With `app_rdy` held high, one strip is accepted per cycle. `app_en` stays high across consecutive strips, and the address advances on every acceptance edge.
- Last write accepted at edge K: `done` is high during cycle K+1 (DONE state), and IDLE follows after K+1.
- Last read data sampled at edge K: `done` is high after K for exactly one cycle.
- Minimum transaction (read, `num_strips = 0`, immediate `app_rdy`, one-cycle read latency) is 4 cycles from `req` to `done`.

## Test plan
- **Read burst:** `req` with read, `req_adr = 0x1000`, `req_num_strips = 3`, `app_rdy = 1`.
  - `app_en` is high for 4 consecutive cycles with `app_addr` 0x1000, 0x1008, 0x1010, 0x1018 and `app_cmd = 001`.
  - Four `app_rd_data_valid` pulses then give `rd_strip_cnt` 0 to 3 and one `done` pulse.
- **Backpressure:** as above, with `app_rdy` low for 3 cycles while `strip_cnt = 1`.
  - `app_en` stays high and `app_addr` holds 0x1008 for those cycles.
  - The strip advances to 2 only on the edge where `app_rdy` returns.
- **Write credits:** write, `req_num_strips = 2`, no credits.
  - `app_en` stays 0.
  - One `wdf_strip_done` gives exactly one accepted command, after which `app_en` drops.
  - `wdf_strip_done` coinciding with `acc` keeps `app_en` high.
  - `done` follows the third acceptance with no read data.
- **Single strip:** read, `req_num_strips = 0`.
  - One command is issued, and `done` follows the first `app_rd_data_valid`.
  - A second valid pulse after `done` changes nothing.
- **Reset mid-ISSUE:** `rst` is asserted while `app_en = 1`, `strip_cnt = 2`.
  - All outputs are 0 in the same cycle, with no `done`.
  - A new `req` after reset starts from `strip_cnt = 0` with the new address.
- **Request while busy:** a second `req` (different address) during ISSUE is ignored. The transaction completes with the original `app_addr` sequence.
